// File: rtl/pcie_trn_tx_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : pcie_trn_tx_arbiter
// Description : Packet-atomic round-robin arbiter that shares the 64-bit TRN
//               transmit port of a Virtex-5 PCIe endpoint among N_REQ TLP
//               sources. Packet starts are gated on per-type transmit buffer
//               availability. Destination discontinue and link loss abort the
//               current packet, and the remainder of that packet is drained
//               from its requester. Completed TLPs are counted.
//
// Ports       : trn_clk, trn_rst       clock, synchronous active-high reset
//               trn_lnk_up_n           link up (active low)
//               req_valid/sof/eof      per-requester beat valid and framing
//               req_td/req_trem_n      per-requester data (64b) / remainder (8b)
//               req_type               per-requester TLP class (2b)
//                                      0 posted, 1 non-posted, 2 cpl, 3 posted
//               req_ready              beat consumed when valid & ready
//               req_grant              one-hot, requester owns the port
//               req_abort              one-cycle pulse, packet was discarded
//               trn_td/trn_trem_n      transmit data / remainder to endpoint
//               trn_tsof_n/teof_n      transmit framing (active low)
//               trn_tsrc_rdy_n         source ready (active low)
//               trn_tsrc_dsc_n         source discontinue (active low)
//               trn_terrfwd_n          error forward, tied inactive
//               trn_tdst_rdy_n/dsc_n   destination ready / discontinue
//               trn_tbuf_av            buffer available: [0] NP, [1] P, [2] CPL
//               pkt_count              completed TLPs, wraps at 16 bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_trn_tx_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                 trn_clk,
    input  logic                 trn_rst,
    input  logic                 trn_lnk_up_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_sof,
    input  logic [N_REQ-1:0]     req_eof,
    input  logic [64*N_REQ-1:0]  req_td,
    input  logic [8*N_REQ-1:0]   req_trem_n,
    input  logic [2*N_REQ-1:0]   req_type,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     req_grant,
    output logic [N_REQ-1:0]     req_abort,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    output logic                 trn_tsrc_dsc_n,
    output logic                 trn_terrfwd_n,
    input  logic                 trn_tdst_rdy_n,
    input  logic                 trn_tdst_dsc_n,
    input  logic [3:0]           trn_tbuf_av,
    output logic [15:0]          pkt_count
);

    // N_REQ is limited to 2..4, so a 2-bit index covers every case above 2.
    localparam int c_IDX_W = (N_REQ > 2) ? 2 : 1;
    localparam int c_SUM_W = c_IDX_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_REQ - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_XFER  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_gidx;
    logic [N_REQ-1:0]    r_grant;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [15:0]         r_pkt_count;
    logic [N_REQ-1:0]    r_abort;
    logic                r_src_dsc;

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic [c_IDX_W-1:0]  w_gidx_nxt;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic [c_IDX_W-1:0]  w_rr_nxt;
    logic                w_pkt_inc;
    logic [N_REQ-1:0]    w_abort_nxt;
    logic                w_src_dsc_nxt;

    // ------------------------------------------------------------------------
    // Per-requester unpacking and eligibility
    // ------------------------------------------------------------------------
    logic [63:0]         w_td_arr   [N_REQ];
    logic [7:0]          w_trem_arr [N_REQ];
    logic [N_REQ-1:0]    w_elig;

    // The fourth buffer-available bit carries no TLP class.
    logic                w_unused_tbuf;
    assign w_unused_tbuf = trn_tbuf_av[3];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [1:0] w_type;
            logic       w_buf_ok;

            assign w_td_arr[gi]   = req_td[64*gi +: 64];
            assign w_trem_arr[gi] = req_trem_n[8*gi +: 8];
            assign w_type         = req_type[2*gi +: 2];

            // Buffer bit ordering differs from the type encoding:
            // type 1 (NP) -> bit 0, type 2 (CPL) -> bit 2, types 0/3 -> bit 1.
            always_comb begin
                case (w_type)
                    2'd1:    w_buf_ok = trn_tbuf_av[0];
                    2'd2:    w_buf_ok = trn_tbuf_av[2];
                    default: w_buf_ok = trn_tbuf_av[1];
                endcase
            end

            assign w_elig[gi] = req_valid[gi] & req_sof[gi] & ~trn_lnk_up_n & w_buf_ok;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search: first eligible requester at or after r_rr_ptr,
    // wrapping modulo N_REQ (N_REQ need not be a power of two).
    // ------------------------------------------------------------------------
    logic                w_win_found;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic [c_SUM_W-1:0]  w_cand;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + c_SUM_W'(k);
            if (w_cand >= c_SUM_W'(N_REQ)) begin
                w_cand = w_cand - c_SUM_W'(N_REQ);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_win_found && w_elig[i] && (w_cand == c_SUM_W'(i))) begin
                    w_win_found = 1'b1;
                    w_win_idx   = c_IDX_W'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Granted requester view
    // ------------------------------------------------------------------------
    logic                w_g_valid;
    logic                w_g_sof;
    logic                w_g_eof;
    logic [c_IDX_W-1:0]  w_next_ptr;
    logic                w_dst_accept;

    assign w_g_valid  = req_valid[r_gidx];
    assign w_g_sof    = req_sof[r_gidx];
    assign w_g_eof    = req_eof[r_gidx];
    assign w_next_ptr = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;

    // A beat may only be consumed when the endpoint can actually accept it:
    // destination ready, no discontinue, and the link still up.
    assign w_dst_accept = ~trn_tdst_rdy_n & trn_tdst_dsc_n & ~trn_lnk_up_n;

    // ------------------------------------------------------------------------
    // FSM next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_gidx_nxt     = r_gidx;
        w_grant_nxt    = r_grant;
        w_rr_nxt       = r_rr_ptr;
        w_pkt_inc      = 1'b0;
        w_abort_nxt    = '0;
        w_src_dsc_nxt  = 1'b0;

        req_ready      = '0;
        trn_td         = '0;
        trn_trem_n     = '0;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = c_ST_XFER;
                    w_gidx_nxt  = w_win_idx;
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                end
            end

            c_ST_XFER: begin
                trn_td         = w_td_arr[r_gidx];
                trn_trem_n     = w_trem_arr[r_gidx];
                trn_tsof_n     = ~w_g_sof;
                trn_teof_n     = ~w_g_eof;
                trn_tsrc_rdy_n = ~w_g_valid;
                req_ready      = r_grant & {N_REQ{w_dst_accept}};

                // Link loss takes priority over discontinue; both override
                // an eof beat presented in the same cycle.
                if (trn_lnk_up_n) begin
                    w_state_nxt   = c_ST_DRAIN;
                    w_abort_nxt   = r_grant;
                    w_src_dsc_nxt = 1'b1;
                end else if (!trn_tdst_dsc_n) begin
                    w_state_nxt   = c_ST_DRAIN;
                    w_abort_nxt   = r_grant;
                end else if (w_g_valid && !trn_tdst_rdy_n && w_g_eof) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_grant_nxt   = '0;
                    w_rr_nxt      = w_next_ptr;
                    w_pkt_inc     = 1'b1;
                end
            end

            c_ST_DRAIN: begin
                // Swallow the rest of the aborted packet; nothing reaches TRN.
                req_ready = r_grant;
                if (w_g_valid && w_g_eof) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_next_ptr;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            r_state     <= c_ST_IDLE;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
            r_abort     <= '0;
            r_src_dsc   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gidx      <= w_gidx_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_pkt_count <= r_pkt_count + 16'(w_pkt_inc);
            r_abort     <= w_abort_nxt;
            r_src_dsc   <= w_src_dsc_nxt;
        end
    end

    assign req_grant      = r_grant;
    assign req_abort      = r_abort;
    assign trn_tsrc_dsc_n = ~r_src_dsc;
    assign trn_terrfwd_n  = 1'b1;
    assign pkt_count      = r_pkt_count;

endmodule
`default_nettype wire
